// File: rtl/reg_file_pkg.sv
// Shared types and sizing helpers for the context-saving register file.
package reg_file_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAVE    = 2'd1,
      RESTORE = 2'd2,
      DONE    = 2'd3
   } xfer_state_t;

   // Total entry count: general registers plus the accumulator.
   function automatic int unsigned num_entries(input int unsigned pw);
      return (32'd1 << pw) + 32'd1;
   endfunction

   // The accumulator sits directly above the last general register.
   function automatic int unsigned acc_index(input int unsigned pw);
      return 32'd1 << pw;
   endfunction

endpackage

// File: rtl/reg_xfer_fsm.sv
// Context-transfer sequencer: walks every entry index once, either presenting
// it on the save stream or accepting it from the restore stream.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | datapath owns the register file, waiting for save/restore
//   SAVE    | streaming entry[cnt] out, advance on sv_valid && sv_ready
//   RESTORE | loading entry[cnt] from rs_dat, advance on rs_valid
//   DONE    | one-cycle completion pulse, then back to IDLE
module reg_xfer_fsm
   import reg_file_pkg::*;
#(
   parameter int PW = 4
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        save_req,
   input  logic        restore_req,
   input  logic        sv_ready,
   input  logic        rs_valid,
   output logic        busy,
   output logic        done,
   output logic        sv_valid,
   output logic        rs_ready,
   output logic [PW:0] idx,
   output logic        ld_en
);

   localparam int unsigned LAST_I = acc_index(PW);
   localparam logic [PW:0] LAST   = LAST_I[PW:0];

   xfer_state_t state;
   logic [PW:0] cnt;

   assign idx   = cnt;
   // rs_ready is exactly (state == RESTORE), so this is the restore handshake.
   assign ld_en = (state == RESTORE) && rs_valid;

   // State, counter and all handshake/status outputs are registered together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sv_valid <= 1'b0;
         rs_ready <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (save_req) begin
                  state    <= SAVE;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  sv_valid <= 1'b1;
               end else if (restore_req) begin
                  state    <= RESTORE;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  rs_ready <= 1'b1;
               end
            end
            SAVE: begin
               if (sv_valid && sv_ready) begin
                  if (cnt == LAST) begin
                     state    <= DONE;
                     sv_valid <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            RESTORE: begin
               if (rs_valid && rs_ready) begin
                  if (cnt == LAST) begin
                     state    <= DONE;
                     rs_ready <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               sv_valid <= 1'b0;
               rs_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/reg_file_ctx.sv
// Register file with 2**PW general registers plus an accumulator, two
// combinational read ports with optional write forwarding, and a save/restore
// stream for spilling and refilling the whole register state.
module reg_file_ctx
   import reg_file_pkg::*;
#(
   parameter int DW     = 8,
   parameter int PW     = 4,
   parameter int BYPASS = 1
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] dat_in,
   input  logic          wr_en,
   input  logic [PW:0]   wr_addr,
   input  logic [PW-1:0] rd_addrA,
   input  logic [PW-1:0] rd_addrB,
   output logic [DW-1:0] datA_out,
   output logic [DW-1:0] datB_out,
   output logic [DW-1:0] acc,
   input  logic          save_req,
   input  logic          restore_req,
   output logic          busy,
   output logic          done,
   output logic          sv_valid,
   input  logic          sv_ready,
   output logic [PW:0]   sv_addr,
   output logic [DW-1:0] sv_dat,
   input  logic          rs_valid,
   output logic          rs_ready,
   input  logic [DW-1:0] rs_dat
);

   localparam int          NUM     = num_entries(PW);
   localparam int unsigned ACC_I   = acc_index(PW);
   localparam logic [PW:0] ACC_IDX = ACC_I[PW:0];

   logic [DW-1:0] mem [NUM];
   logic [PW:0]   idx;
   logic          ld_en;
   logic          wr_ok;
   logic          fwd;
   logic [PW:0]   rd_a_idx;
   logic [PW:0]   rd_b_idx;

   reg_xfer_fsm #(.PW(PW)) u_xfer (
      .clk         (clk),
      .reset       (reset),
      .save_req    (save_req),
      .restore_req (restore_req),
      .sv_ready    (sv_ready),
      .rs_valid    (rs_valid),
      .busy        (busy),
      .done        (done),
      .sv_valid    (sv_valid),
      .rs_ready    (rs_ready),
      .idx         (idx),
      .ld_en       (ld_en)
   );

   // Datapath writes only land while the sequencer is idle; addresses above
   // the accumulator are silently dropped.
   assign wr_ok    = wr_en && !busy && (wr_addr <= ACC_IDX);
   assign fwd      = (BYPASS != 0) && wr_ok;
   assign rd_a_idx = {1'b0, rd_addrA};
   assign rd_b_idx = {1'b0, rd_addrB};

   // Restore data is never forwarded: it appears on the read ports the cycle
   // after it is stored.
   assign datA_out = (fwd && (wr_addr == rd_a_idx)) ? dat_in : mem[rd_a_idx];
   assign datB_out = (fwd && (wr_addr == rd_b_idx)) ? dat_in : mem[rd_b_idx];
   assign acc      = (fwd && (wr_addr == ACC_IDX))  ? dat_in : mem[ACC_IDX];

   // Save stream reads straight from storage at the sequencer index, so it
   // holds steady while the sink stalls.
   assign sv_addr = idx;
   assign sv_dat  = mem[idx];

   // Entry storage: restore loads take precedence over (blocked) datapath writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM; i++) begin
            mem[i] <= '0;
         end
      end else if (ld_en) begin
         mem[idx] <= rs_dat;
      end else if (wr_ok) begin
         mem[wr_addr] <= dat_in;
      end
   end

endmodule
